// File: rtl/os_sa_pkg.sv
// ============================================================================
// os_sa_pkg : shared state encoding and flush-length helper for os_array_ctrl
// Revision  : 1.0
// ============================================================================
`default_nettype none

package os_sa_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_FLUSH = 3'd2,
    S_LOAD  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // One read-latency cycle, 2(N-1) skew cycles and one PE-latency cycle.
  function automatic int flush_cycles(input int n);
    return 2 * n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/os_ctrl_perf.sv
// ============================================================================
// os_ctrl_perf : saturating busy-cycle and drain-stall-cycle counters
// Revision     : 1.0
// ============================================================================
`default_nettype none

module os_ctrl_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        busy,
  input  logic        stall,
  output logic [31:0] busy_cyc,
  output logic [31:0] stall_cyc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cyc  <= '0;
      stall_cyc <= '0;
    end else begin
      if (busy && (busy_cyc != '1))
        busy_cyc <= busy_cyc + 32'd1;
      if (stall && (stall_cyc != '1))
        stall_cyc <= stall_cyc + 32'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/os_array_ctrl.sv
// ============================================================================
// os_array_ctrl : output-stationary PE array sequencer (feed, flush, load, drain)
// Optional counters selected by macro OS_ARRAY_CTRL_PERF_EN.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module os_array_ctrl
  import os_sa_pkg::*;
#(
  parameter int ARRAY_SIZE = 4,
  parameter int K_MAX      = 64,
  parameter int ADDR_W     = $clog2(K_MAX),
  localparam int K_W       = $clog2(K_MAX + 1),
  localparam int COL_W     = $clog2(ARRAY_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [K_W-1:0]    cmd_k,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              feed_en,
  output logic              acc_clr,
  output logic              load_en,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [COL_W-1:0]  res_col,
  output logic              shift_en,
  output logic              busy,
  output logic              done,
  output logic [31:0]       perf_busy_cyc,
  output logic [31:0]       perf_stall_cyc
);

  localparam int FLUSH_CYCLES = flush_cycles(ARRAY_SIZE);
  localparam int FL_W         = $clog2(FLUSH_CYCLES + 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [FL_W-1:0]   flush_cnt, flush_n;
  logic [COL_W-1:0]  beat, beat_n;
  logic [K_W-1:0]    k_q, k_n;
  logic [K_W-1:0]    k_sat;

  assign k_sat = (cmd_k > K_W'(K_MAX)) ? K_W'(K_MAX) : cmd_k;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      flush_cnt <= '0;
      beat      <= '0;
      k_q       <= '0;
      feed_en   <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      flush_cnt <= flush_n;
      beat      <= beat_n;
      k_q       <= k_n;
      feed_en   <= rd_en;
    end
  end

  always_comb begin
    state_n   = state;
    addr_n    = addr;
    flush_n   = flush_cnt;
    beat_n    = beat;
    k_n       = k_q;
    cmd_ready = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    acc_clr   = 1'b0;
    load_en   = 1'b0;
    res_valid = 1'b0;
    res_col   = '0;
    shift_en  = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_n  = '0;
          flush_n = '0;
          beat_n  = '0;
          k_n     = k_sat;
          state_n = (k_sat == '0) ? S_DONE : S_FEED;
        end
      end
      S_FEED: begin
        rd_en   = 1'b1;
        rd_addr = addr;
        acc_clr = (addr == '0);
        if (K_W'(addr) == (k_q - K_W'(1))) begin
          flush_n = '0;
          state_n = S_FLUSH;
        end else begin
          addr_n = addr + 1'b1;
        end
      end
      S_FLUSH: begin
        if (flush_cnt == FL_W'(FLUSH_CYCLES - 1))
          state_n = S_LOAD;
        else
          flush_n = flush_cnt + 1'b1;
      end
      S_LOAD: begin
        load_en = 1'b1;
        beat_n  = '0;
        state_n = S_DRAIN;
      end
      S_DRAIN: begin
        res_valid = 1'b1;
        res_col   = beat;
        // The final column needs no shift; it leaves straight from column 0.
        if (res_ready) begin
          if (beat == COL_W'(ARRAY_SIZE - 1)) begin
            state_n = S_DONE;
          end else begin
            shift_en = 1'b1;
            beat_n   = beat + 1'b1;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

`ifdef OS_ARRAY_CTRL_PERF_EN
  logic drain_stall;
  assign drain_stall = (state == S_DRAIN) && !res_ready;

  os_ctrl_perf u_perf (
    .clk       (clk),
    .rst       (rst),
    .busy      (busy),
    .stall     (drain_stall),
    .busy_cyc  (perf_busy_cyc),
    .stall_cyc (perf_stall_cyc)
  );
`else
  assign perf_busy_cyc  = 32'd0;
  assign perf_stall_cyc = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_os_array_ctrl.sv
// ============================================================================
// tb_os_array_ctrl : scoreboard bench for os_array_ctrl with a timing model
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_os_array_ctrl;

  localparam int N     = 4;
  localparam int K_MAX = 64;
  localparam int FL    = 2 * N;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [6:0]  cmd_k = '0;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic        feed_en, acc_clr, load_en, res_valid, shift_en, busy, done;
  logic        res_ready = 1'b1;
  logic [1:0]  res_col;
  logic [31:0] perf_busy_cyc, perf_stall_cyc;

  int checks = 0;
  int failures = 0;

  int exp_addr[$];
  int exp_col[$];

  bit in_cmd = 0;
  int cyc = 0, acc_cyc = 0, ks = 0, beats = 0, done_due = -1;
  int tot_busy = 0, tot_stall = 0;
  int rr_mode = 0;

  os_array_ctrl #(.ARRAY_SIZE(N), .K_MAX(K_MAX)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k(cmd_k),
    .rd_en(rd_en), .rd_addr(rd_addr), .feed_en(feed_en), .acc_clr(acc_clr),
    .load_en(load_en), .res_valid(res_valid), .res_ready(res_ready), .res_col(res_col),
    .shift_en(shift_en), .busy(busy), .done(done),
    .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference timing: a command of k>0 reads on offsets 1..k, flushes 2N cycles,
  // loads once, drains N beats (plus stalls) and signals done the cycle after.
  always @(negedge clk) begin
    int  off, col_exp;
    bit  e_rd, e_clr, e_feed, e_load, e_drain, e_done, was_in;
    cyc++;
    if (rst) begin
      in_cmd    = 0;
      beats     = 0;
      done_due  = -1;
      tot_busy  = 0;
      tot_stall = 0;
    end else begin
      off     = cyc - acc_cyc;
      was_in  = in_cmd;
      e_rd    = in_cmd && ks > 0 && off >= 1 && off <= ks;
      e_clr   = in_cmd && ks > 0 && off == 1;
      e_feed  = in_cmd && ks > 0 && off >= 2 && off <= ks + 1;
      e_load  = in_cmd && ks > 0 && off == ks + FL + 1;
      e_drain = in_cmd && ks > 0 && off >= ks + FL + 2 && beats < N;
      e_done  = in_cmd && cyc == done_due;
      chk("busy", busy, in_cmd);
      chk("cmd_ready", cmd_ready, !in_cmd);
      chk("rd_en", rd_en, e_rd);
      chk("acc_clr", acc_clr, e_clr);
      chk("feed_en", feed_en, e_feed);
      chk("load_en", load_en, e_load);
      chk("res_valid", res_valid, e_drain);
      chk("done", done, e_done);
      if (!in_cmd) begin
        chk("idle_rd_addr", rd_addr, 0);
        chk("idle_res_col", res_col, 0);
      end
      if (rd_en) begin
        if (exp_addr.size() == 0) chk("rd_addr_unexpected", 1, 0);
        else chk("rd_addr", rd_addr, exp_addr.pop_front());
      end
      if (e_drain) begin
        col_exp = (exp_col.size() > 0) ? exp_col[0] : -1;
        chk("res_col", res_col, col_exp);
        chk("shift_en", shift_en, res_ready && col_exp != N - 1);
        if (res_ready) begin
          if (exp_col.size() > 0) void'(exp_col.pop_front());
          beats++;
          if (beats == N) done_due = cyc + 1;
        end else begin
          tot_stall++;
        end
      end else begin
        chk("shift_en_idle", shift_en, 0);
      end
      if (in_cmd) tot_busy++;
      if (e_done) in_cmd = 0;
      if (!was_in && cmd_valid) begin
        in_cmd   = 1;
        acc_cyc  = cyc;
        ks       = (cmd_k > K_MAX) ? K_MAX : int'(cmd_k);
        beats    = 0;
        done_due = (ks == 0) ? cyc + 1 : -1;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rr_mode == 1) res_ready = ($urandom_range(0, 3) != 0);
    else if (rr_mode == 0) res_ready = 1'b1;
  end

  task automatic send(input int k, input int n);
    int ksat;
    bit got;
    cmd_k = 7'(k);
    cmd_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      got = 0;
      for (int t = 0; t < 3000 && !got; t++) begin
        @(negedge clk);
        if (cmd_ready) got = 1;
      end
      if (!got) begin
        chk("accept_timeout", 0, 1);
        break;
      end
      ksat = (k > K_MAX) ? K_MAX : k;
      for (int a = 0; a < ksat; a++) exp_addr.push_back(a);
      if (ksat > 0) for (int c = 0; c < N; c++) exp_col.push_back(c);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int t = 0; t < 3000 && !idle; t++) begin
      @(posedge clk); #2;
      if (!in_cmd && !busy) idle = 1;
    end
    if (!idle) chk("idle_timeout", 0, 1);
  endtask

  task automatic perf_check();
    @(posedge clk); #2;
`ifdef OS_ARRAY_CTRL_PERF_EN
    chk("perf_busy_cyc", perf_busy_cyc, tot_busy);
    chk("perf_stall_cyc", perf_stall_cyc, tot_stall);
`else
    chk("perf_busy_tied", perf_busy_cyc, 0);
    chk("perf_stall_tied", perf_stall_cyc, 0);
`endif
  endtask

  initial begin
    longint s0;
    int k;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    perf_check();

    // Nominal k=4, zero-length command, saturation at K_MAX.
    rr_mode = 0;
    send(4, 1);   wait_idle(); perf_check();
    send(0, 1);   wait_idle(); perf_check();
    send(100, 1); wait_idle(); perf_check();

    // Three-cycle stall on beat 1.
    rr_mode = 2;
    res_ready = 1'b1;
    s0 = perf_stall_cyc;
    send(2, 1);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (res_valid && res_col == 2'd0) break;
    end
    @(posedge clk); #1 res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 res_ready = 1'b1;
    wait_idle();
`ifdef OS_ARRAY_CTRL_PERF_EN
    chk("stall_delta", perf_stall_cyc - s0, 3);
`endif
    perf_check();

    // cmd_valid held high across two back-to-back commands.
    rr_mode = 0;
    send(3, 2); wait_idle(); perf_check();

    // Reset during FLUSH of a k=8 command, then a normal k=1 command.
    send(8, 1);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    exp_addr.delete();
    exp_col.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    perf_check();
    send(1, 1); wait_idle(); perf_check();

    // Randomized commands with random back-pressure.
    rr_mode = 1;
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 7))
        0:       k = $urandom_range(0, 2);
        1:       k = $urandom_range(K_MAX - 1, 127);
        default: k = $urandom_range(1, 20);
      endcase
      send(k, 1);
      wait_idle();
      perf_check();
    end
    rr_mode = 0;
    repeat (3) @(posedge clk);

    chk("addr_queue_empty", exp_addr.size(), 0);
    chk("col_queue_empty", exp_col.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
